// File: rtl/serial_rx.sv
// serial_rx: UART receiver, 8N1 by default, or 8E1 when SERIAL_RX_PARITY_EN is defined.
// Samples each bit in the middle of its bit time and presents each received byte with a one-cycle strobe.
// Ports:
//   CLK        system clock
//   RESET      asynchronous active-low reset
//   ENABLE     clock enable; low freezes the FSM, the counters and DATA
//   RX         raw serial line, idle high, asynchronous to CLK
//   DATA       last correctly framed byte (line order is LSB first)
//   VALID      one-cycle strobe: DATA was updated this cycle
//   FRAME_ERR  one-cycle strobe: stop bit was sampled low
//   PARITY_ERR one-cycle strobe: even parity failed (SERIAL_RX_PARITY_EN builds only)
module serial_rx #(
    parameter int CLK_FREQ = 100000000,
    parameter int BAUD     = 9600
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       ENABLE,
    input  logic       RX,
    output logic [7:0] DATA,
    output logic       VALID,
    output logic       FRAME_ERR
`ifdef SERIAL_RX_PARITY_EN
    ,
    output logic       PARITY_ERR
`endif
);
    localparam int DIV  = CLK_FREQ / BAUD;
    localparam int HALF = DIV / 2;
    localparam int CW   = $clog2(DIV);

    if (DIV < 4) begin : g_div_chk
        $error("serial_rx: CLK_FREQ/BAUD must be at least 4");
    end

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK} state_t;

`ifdef SERIAL_RX_PARITY_EN
    localparam state_t AFTER_DATA = S_PARITY;
`else
    localparam state_t AFTER_DATA = S_STOP;
`endif

    state_t        state;
    logic [CW-1:0] cnt;
    logic [2:0]    idx;
    logic [7:0]    shift;
    logic [1:0]    sync;
    logic          rx_s;
    logic          tick;
    logic          good;

    assign rx_s = sync[1];
    assign tick = (cnt == '0);

`ifdef SERIAL_RX_PARITY_EN
    logic par;
    // Stop bit is high and the data bits plus the parity bit have even weight.
    assign good = rx_s & ~(^shift ^ par);
`else
    assign good = rx_s;
`endif

    // The synchroniser runs on every clock, so ENABLE never delays it.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) sync <= 2'b11;
        else        sync <= {sync[0], RX};
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state     <= S_IDLE;
            cnt       <= '0;
            idx       <= '0;
            shift     <= '0;
            DATA      <= '0;
            VALID     <= 1'b0;
            FRAME_ERR <= 1'b0;
`ifdef SERIAL_RX_PARITY_EN
            par        <= 1'b0;
            PARITY_ERR <= 1'b0;
`endif
        end else begin
            VALID     <= 1'b0;
            FRAME_ERR <= 1'b0;
`ifdef SERIAL_RX_PARITY_EN
            PARITY_ERR <= 1'b0;
`endif
            if (ENABLE) begin
                // Counter parks at zero; any reload below takes precedence.
                if (!tick) cnt <= cnt - CW'(1);
                case (state)
                    S_IDLE: if (!rx_s) begin
                        state <= S_START;
                        cnt   <= CW'(HALF - 1);
                    end
                    S_START: if (tick) begin
                        state <= rx_s ? S_IDLE : S_DATA;
                        cnt   <= CW'(DIV - 1);
                        idx   <= '0;
                    end
                    S_DATA: if (tick) begin
                        shift <= {rx_s, shift[7:1]};
                        cnt   <= CW'(DIV - 1);
                        idx   <= idx + 3'd1;
                        state <= (idx == 3'd7) ? AFTER_DATA : S_DATA;
                    end
`ifdef SERIAL_RX_PARITY_EN
                    S_PARITY: if (tick) begin
                        par   <= rx_s;
                        cnt   <= CW'(DIV - 1);
                        state <= S_STOP;
                    end
`endif
                    // Returning to IDLE at mid-stop-bit leaves time to catch a back-to-back start edge.
                    S_STOP: if (tick) begin
                        state     <= rx_s ? S_IDLE : S_BREAK;
                        FRAME_ERR <= ~rx_s;
                        VALID     <= good;
`ifdef SERIAL_RX_PARITY_EN
                        PARITY_ERR <= rx_s & ~good;
`endif
                        if (good) DATA <= shift;
                    end
                    // A held-low line must produce only one FRAME_ERR, so wait here for idle.
                    S_BREAK: if (rx_s) state <= S_IDLE;
                    default: state <= S_IDLE;
                endcase
            end
        end
    end
endmodule
